cpu_host_seq: RTL

- Host-side sequencer that drives the single-cycle CPU core's req/done handshake.
- Streams an initial data-memory image into the core's data memory, pulses core reset, issues req and waits for done under a watchdog.
- Then reads a result window back out of data memory and streams it upstream.
- Sits between the bench/SoC host interface and the CPU top level; owns the data-memory host port whenever the core is not running.

---
 rtl/host_pkg.sv | 22 ++
 rtl/host_watchdog.sv | 38 +++
 rtl/cpu_host_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/host_pkg.sv
// Shared types and default parameters for the CPU host sequencer.
package host_pkg;

    localparam int unsigned HOST_AW      = 8;
    localparam int unsigned HOST_DW      = 8;
    localparam int unsigned HOST_CW      = 16;
    localparam int unsigned HOST_RST_CYC = 2;
    localparam int unsigned HOST_TIMEOUT = 4096;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_CRST    = 4'd2,
        S_RUN     = 4'd3,
        S_RD_ADDR = 4'd4,
        S_RD_WAIT = 4'd5,
        S_RD_HOLD = 4'd6,
        S_FIN     = 4'd7,
        S_ERR     = 4'd8
    } host_state_t;

endpackage

// File: rtl/host_watchdog.sv
// Saturating RUN-cycle counter with timeout detect for the host sequencer.
module host_watchdog #(
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          timeout_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle whose increment makes the count reach TIMEOUT-1.
    assign timeout_o = en_i && (cnt_q >= CW'(TIMEOUT - 2));
    assign count_o   = cnt_q;

endmodule

// File: rtl/cpu_host_seq.sv
// Host sequencer: load data memory, reset and run the core, read results back.
// Optional checksum accumulator enabled by defining HOST_CHECKSUM_EN.
module cpu_host_seq
    import host_pkg::*;
#(
    parameter int unsigned AW      = HOST_AW,
    parameter int unsigned DW      = HOST_DW,
    parameter int unsigned CW      = HOST_CW,
    parameter int unsigned RST_CYC = HOST_RST_CYC,
    parameter int unsigned TIMEOUT = HOST_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] rd_len,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          busy,
    output logic          job_ok,
    output logic          job_err,
    output logic [CW-1:0] run_cycles,
    output logic [DW-1:0] res_sum,
    output logic [3:0]    state_dbg
);

    // Handshakes (ld_*, res_*): a word transfers on a rising clk edge where
    // valid and ready are both high; valid and payload hold until then.

    host_state_t   state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic [7:0]    crst_cnt_q, crst_cnt_d;
    logic          first_q, first_d;
    logic          job_ok_q, job_ok_d;
    logic          job_err_q, job_err_d;
    logic          parked_q, parked_d;
    logic          start_acc;
    logic          wd_timeout;

    host_watchdog #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk),
        .reset_i   (reset),
        .clr_i     (start_acc),
        .en_i      (state_q == S_RUN),
        .count_o   (run_cycles),
        .timeout_o (wd_timeout)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        res_data_d  = res_data_q;
        crst_cnt_d  = crst_cnt_q;
        first_d     = first_q;
        job_ok_d    = job_ok_q;
        job_err_d   = job_err_q;
        parked_d    = parked_q;
        start_acc   = 1'b0;
        ld_ready    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        res_valid   = 1'b0;
        core_req    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    base_d    = rd_base;
                    len_d     = rd_len;
                    job_ok_d  = 1'b0;
                    job_err_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready    = 1'b1;
                mem_addr    = ld_addr;
                mem_wr_data = ld_data;
                if (ld_valid) begin
                    mem_wr_en = 1'b1;
                    if (ld_last) begin
                        crst_cnt_d = '0;
                        state_d    = S_CRST;
                    end
                end
            end
            S_CRST: begin
                if (crst_cnt_q == 8'(RST_CYC - 1)) begin
                    first_d  = 1'b1;
                    parked_d = 1'b0;
                    state_d  = S_RUN;
                end else begin
                    crst_cnt_d = crst_cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                core_req = first_q;
                first_d  = 1'b0;
                // The core may still show done from a previous job in its first cycle.
                if (!first_q && core_done) begin
                    idx_d = '0;
                    if (len_q == '0) begin
                        job_ok_d = 1'b1;
                        state_d  = S_FIN;
                    end else begin
                        state_d = S_RD_ADDR;
                    end
                end else if (wd_timeout) begin
                    job_err_d = 1'b1;
                    parked_d  = 1'b1;
                    state_d   = S_ERR;
                end
            end
            S_RD_ADDR: begin
                mem_addr = base_q + idx_q;
                state_d  = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                mem_addr   = base_q + idx_q;
                res_data_d = mem_rd_data;
                state_d    = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    idx_d = idx_q + AW'(1);
                    if ((idx_q + AW'(1)) == len_q) begin
                        job_ok_d = 1'b1;
                        state_d  = S_FIN;
                    end else begin
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            res_data_q <= '0;
            crst_cnt_q <= '0;
            first_q    <= 1'b0;
            job_ok_q   <= 1'b0;
            job_err_q  <= 1'b0;
            parked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            res_data_q <= res_data_d;
            crst_cnt_q <= crst_cnt_d;
            first_q    <= first_d;
            job_ok_q   <= job_ok_d;
            job_err_q  <= job_err_d;
            parked_q   <= parked_d;
        end
    end

    // After a timeout the core stays parked in reset until the next job runs it.
    assign core_reset = reset || (state_q == S_CRST) || (state_q == S_ERR) || parked_q;
    assign busy       = (state_q != S_IDLE);
    assign res_data   = res_data_q;
    assign job_ok     = job_ok_q;
    assign job_err    = job_err_q;
    assign state_dbg  = state_q;

`ifdef HOST_CHECKSUM_EN
    logic [DW-1:0] sum_q;
    logic          res_hs;

    assign res_hs = (state_q == S_RD_HOLD) && res_ready;

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            sum_q <= '0;
        end else if (res_hs) begin
            sum_q <= sum_q + res_data_q;
        end
    end

    assign res_sum = sum_q;
`else
    assign res_sum = '0;
`endif

endmodule
